// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the non-restoring divider (div_defs): FSM state
// encoding and the iteration-counter sizing helper. The WIDTH-dependent
// constants MOST_NEG / ALL_ONES are derived from these in the top.
package nonrestoring_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Request/result bundle for the non-restoring divider.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid (and its data) until that edge;
// ready may change freely and never depends combinationally on valid.
// Request side: in_valid/in_ready carry dividend+divisor.
// Result side: out_valid/out_ready carry quotient, remainder, div_by_zero.
interface nonrestoring_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_divider_substep.sv
// One combinational non-restoring division step (div_substep).
// P is the WIDTH+1-bit signed partial remainder, A shifts dividend bits out
// of its msb and quotient bits into its lsb, D is the unsigned divisor.
module div_substep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_p,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_next_p,
  output logic [WIDTH-1:0] o_next_a
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_d_ext;

  // |P| < D <= 2^(WIDTH-1), so dropping P's top bit before the shift loses
  // nothing and the shifted value still fits in WIDTH+1 signed bits.
  always_comb begin
    w_shifted = {i_p[WIDTH-1:0], i_a[WIDTH-1]};
    w_d_ext   = {1'b0, i_d};
    if (!i_p[WIDTH]) begin
      o_next_p = w_shifted - w_d_ext;
    end else begin
      o_next_p = w_shifted + w_d_ext;
    end
    o_next_a = {i_a[WIDTH-2:0], ~o_next_p[WIDTH]};
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider, one quotient bit per cycle (non-restoring).
// Quotient truncates toward zero; remainder takes the dividend's sign.
// WIDTH must be even and at least 4.
// Optional macro DIV_SPECIAL_FASTPATH_EN: divide-by-zero, MOST_NEG/-1 and
// |dividend|<|divisor| skip the iterative steps (result one cycle after
// accept). Results are identical with or without the macro.
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  nonrestoring_divider_if.slave       bus,
  output state_t                      o_dbg_state
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           r_state;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_dvd;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [CW-1:0]    r_cnt;
  logic             r_spec_dbz;
  logic             r_spec_ovf;
  logic             r_spec_small;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_is_dbz;
  logic             w_is_ovf;
  logic             w_is_small;
  logic             w_accept;
  logic [WIDTH:0]   w_next_p;
  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot_signed;
  logic [WIDTH-1:0] w_rem_signed;

  // Operand magnitudes; MOST_NEG maps to unsigned 2^(WIDTH-1), which fits.
  always_comb begin
    w_dvd_mag  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    w_dvs_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    w_is_dbz   = (bus.divisor == '0);
    w_is_ovf   = (bus.dividend == MOST_NEG) && (bus.divisor == ALL_ONES);
`ifdef DIV_SPECIAL_FASTPATH_EN
    w_is_small = (w_dvd_mag < w_dvs_mag);
`else
    w_is_small = 1'b0;
`endif
    w_accept   = bus.in_valid & r_in_ready;
  end

  div_substep #(.WIDTH(WIDTH)) u_substep (
    .i_p      (r_p),
    .i_a      (r_a),
    .i_d      (r_d),
    .o_next_p (w_next_p),
    .o_next_a (w_next_a)
  );

  // Final correction: restore a negative remainder, then apply the signs.
  always_comb begin
    w_rem_mag     = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d) : r_p[WIDTH-1:0];
    w_quot_signed = r_sign_q ? -r_a : r_a;
    w_rem_signed  = r_sign_r ? -w_rem_mag : w_rem_mag;
  end

  // Control FSM plus datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_p          <= '0;
      r_a          <= '0;
      r_d          <= '0;
      r_dvd        <= '0;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
      r_cnt        <= '0;
      r_spec_dbz   <= 1'b0;
      r_spec_ovf   <= 1'b0;
      r_spec_small <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_quot       <= '0;
      r_rem        <= '0;
      r_dbz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_p          <= '0;
            r_a          <= w_dvd_mag;
            r_d          <= w_dvs_mag;
            r_dvd        <= bus.dividend;
            r_sign_q     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_sign_r     <= bus.dividend[WIDTH-1];
            r_cnt        <= CW'(WIDTH);
            r_spec_dbz   <= w_is_dbz;
            r_spec_ovf   <= w_is_ovf;
            r_spec_small <= w_is_small;
            r_in_ready   <= 1'b0;
`ifdef DIV_SPECIAL_FASTPATH_EN
            // Special results need no iteration; FIX forces them directly.
            r_state      <= (w_is_dbz | w_is_ovf | w_is_small) ? S_FIX : S_CALC;
`else
            r_state      <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          // WIDTH steps, then one hand-over cycle once the counter hits zero.
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_p   <= w_next_p;
            r_a   <= w_next_a;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (r_spec_dbz) begin
            r_quot <= ALL_ONES;
            r_rem  <= r_dvd;
            r_dbz  <= 1'b1;
          end else if (r_spec_ovf) begin
            r_quot <= MOST_NEG;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
          end else if (r_spec_small) begin
            r_quot <= '0;
            r_rem  <= r_dvd;
            r_dbz  <= 1'b0;
          end else begin
            r_quot <= w_quot_signed;
            r_rem  <= w_rem_signed;
            r_dbz  <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // in_ready only rises after release, so no accept in that cycle.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Bench for nonrestoring_divider: directed signed cases, special cases,
// result hold/backpressure, mid-operation reset, then randomized pairs
// against an arithmetic reference model.
module tb_nonrestoring_divider;
  import nonrestoring_divider_pkg::*;

  localparam int              W        = 32;
  localparam int              RW       = 2 * W + 1;
  localparam logic [W-1:0]    MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic   clk;
  logic   rst;
  state_t dbg_state;

  nonrestoring_divider_if #(.WIDTH(W)) bus();

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed as {div_by_zero, quotient, remainder}.
  function automatic logic [RW-1:0] ref_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    longint a, b, q, r;
    logic   z;
    a = longint'($signed(dvd));
    b = longint'($signed(dvs));
    z = 1'b0;
    if (b == 0) begin
      q = -1;
      r = a;
      z = 1'b1;
    end else if (a == -(longint'(1) << (W - 1)) && b == -1) begin
      q = a;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {z, q[W-1:0], r[W-1:0]};
  endfunction

  // Edges from the accept edge until out_valid is visible.
  function automatic int ref_lat(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    longint a, b, abs_a, abs_b;
    bit     special;
    bit     fast;
    a       = longint'($signed(dvd));
    b       = longint'($signed(dvs));
    abs_a   = (a < 0) ? -a : a;
    abs_b   = (b < 0) ? -b : b;
    special = (b == 0) || (a == -(longint'(1) << (W - 1)) && b == -1) || (abs_a < abs_b);
    fast    = 1'b0;
`ifdef DIV_SPECIAL_FASTPATH_EN
    fast    = 1'b1;
`endif
    return (fast && special) ? 1 : W + 2;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input int hold);
    logic [RW-1:0] e;
    int            n;
    int            lat;
    exp_q.push_back(ref_div(dvd, dvs));
    lat = ref_lat(dvd, dvs);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      bus.in_valid = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b0;
    chk("latency", n, lat);
    chk("out_valid", bus.out_valid, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("quotient", bus.quotient, e[2*W-1:W]);
    chk("remainder", bus.remainder, e[W-1:0]);
    chk("div_by_zero", bus.div_by_zero, e[RW-1]);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_quotient", bus.quotient, e[2*W-1:W]);
      chk("hold_remainder", bus.remainder, e[W-1:0]);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
  endtask

  // ---------------- directed table ----------------
  logic [W-1:0] dir_a [0:10];
  logic [W-1:0] dir_b [0:10];

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_div_by_zero", bus.div_by_zero, 0);
    chk("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    dir_a = '{32'd100, -32'd100, 32'd100, -32'd100, MOST_NEG, MOST_NEG,
              32'd55, 32'd5, -32'd5, -32'd55, 32'd0};
    dir_b = '{32'd7, 32'd7, -32'd7, -32'd7, 32'hFFFF_FFFF, 32'd1,
              32'd0, 32'd9, 32'd9, 32'd0, -32'd3};
    for (int i = 0; i < 11; i++) begin
      run_op(dir_a[i], dir_b[i], 0);
    end

    // Backpressure: result held 10 cycles while requests are offered.
    run_op(32'd100, 32'd7, 10);

    // Abort mid-calculation with reset.
    bus.in_valid = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("abort_in_calc", dbg_state, S_CALC);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_div_by_zero", bus.div_by_zero, 0);
    chk("abort_state", dbg_state, S_IDLE);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    run_op(32'd7, 32'd2, 0);

    // Randomized pairs with a bias toward special and small operands.
    for (int i = 0; i < 1200; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           sel;
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = '0;
        1: begin a = MOST_NEG; b = '1; end
        2: b = b >> $urandom_range(1, 31);
        3: a = a >> $urandom_range(1, 31);
        4: a = MOST_NEG;
        5: b = MOST_NEG;
        default: ;
      endcase
      if (sel == 2 && $urandom_range(0, 1) == 1) b = -b;
      if (sel == 3 && $urandom_range(0, 1) == 1) a = -a;
      run_op(a, b, $urandom_range(0, 2));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
